// File: rtl/seq_pkg.sv
// seq_pkg: player FSM state encodings and the speed-to-display-duration table.
package seq_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SHOW, GAP, DONE} state_t;

    function automatic logic [3:0] show_ticks(input logic [1:0] speed);
        return speed == 2'b00 ? 4'd8 : speed == 2'b01 ? 4'd6 : speed == 2'b10 ? 4'd4 : 4'd2;
    endfunction

endpackage

// File: rtl/seq_player_tick_gen.sv
// tick_gen: prescaler pulsing tick every TICK_DIV cycles; clear restarts the count.
module tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clock_50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == W'(TICK_DIV - 1);

    always_comb cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clock_50) cnt_q <= reset ? '0 : cnt_d;

endmodule

// File: rtl/seq_player.sv
// seq_player: plays round+1 pattern-ROM elements on the LEDs, each shown then blanked
// for a speed-dependent number of display ticks, then reports completion.
module seq_player
    import seq_pkg::*;
#(
    parameter int TICK_DIV = 5000000,
    parameter int SEQ_W    = 4
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       round,
    input  logic [1:0]       speed,
    output logic [3:0]       rom_addr,
    input  logic [SEQ_W-1:0] rom_data,
    output logic [SEQ_W-1:0] led_out,
    output logic             busy,
    output logic             end_fpga
);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d, round_q, round_d, tcnt_q, tcnt_d;
    logic [1:0]       speed_q, speed_d;
    logic [SEQ_W-1:0] led_q, led_d;
    logic [3:0]       show_t, gap_t;
    logic             tick, clear;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock_50(clock_50),
        .reset   (reset),
        .clear   (clear),
        .tick    (tick)
    );

    assign show_t   = show_ticks(speed_q);
    assign gap_t    = show_t >> 1;
    assign rom_addr = idx_q;
    assign led_out  = state_q == SHOW ? led_q : '0;
    assign busy     = state_q != IDLE && state_q != DONE;
    assign end_fpga = state_q == DONE;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        round_d = round_q;
        speed_d = speed_q;
        led_d   = led_q;
        tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                idx_d   = '0;
                round_d = round;
                speed_d = speed;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                state_d = SHOW;
                led_d   = rom_data;
            end
            SHOW: if (tick && tcnt_q == show_t - 4'd1) state_d = GAP;
            GAP: if (tick && tcnt_q == gap_t - 4'd1) begin
                state_d = idx_q == round_q ? DONE : FETCH;
                idx_d   = idx_q == round_q ? idx_q : idx_q + 1'b1;
            end
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!start && busy) state_d = IDLE;
        // Any state change restarts both the prescaler and the tick count.
        clear = state_d != state_q;
        if (clear) tcnt_d = '0;
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            round_q <= '0;
            speed_q <= '0;
            tcnt_q  <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            speed_q <= speed_d;
            tcnt_q  <= tcnt_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed vectors for seq_player with TICK_DIV=4; expected
// output words are {led_out, busy, end_fpga, rom_addr}.
module tb_seq_player;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] round, rom_addr, rom_data, led_out;
    logic [1:0] speed;
    logic       busy, end_fpga;
    logic [3:0] rom [16];
    int         n_cmp = 0, n_bad = 0;
    int         per, total, k, o;

    always #10 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    seq_player #(.TICK_DIV(4), .SEQ_W(4)) dut (
        .clock_50(clk),
        .reset   (reset),
        .start   (start),
        .round   (round),
        .speed   (speed),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .led_out (led_out),
        .busy    (busy),
        .end_fpga(end_fpga)
    );

    typedef struct {
        logic [3:0] rnd;
        logic [1:0] spd;
        int         show_c;
        int         gap_c;
        logic [3:0] r0, r1, r2;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [9:0] pk(logic [3:0] l, logic b, logic e, logic [3:0] a);
        return {l, b, e, a};
    endfunction

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int c, input logic [9:0] exp);
        logic [9:0] act;
        act = pk(led_out, busy, end_fpga, rom_addr);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got {led,busy,end,addr}=%h/%b/%b/%h want %h/%b/%b/%h",
                     name, c, act[9:6], act[5], act[4], act[3:0], exp[9:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    initial begin
        vecs[0] = '{4'd0,  2'b11, 8,  4,  4'hA, 4'h0, 4'h0};
        vecs[1] = '{4'd2,  2'b00, 32, 16, 4'h1, 4'h2, 4'h4};
        vecs[2] = '{4'd1,  2'b01, 24, 12, 4'h9, 4'h6, 4'h0};
        vecs[3] = '{4'd3,  2'b10, 16, 8,  4'hF, 4'h3, 4'h5};
        vecs[4] = '{4'd15, 2'b11, 8,  4,  4'h0, 4'h1, 4'h2};
        for (int i = 0; i < 16; i++) rom[i] = 4'(i);
        reset = 1'b1;
        start = 1'b0;
        round = 4'd0;
        speed = 2'b00;
        step;
        step;
        chk("reset_state", 0, pk(4'h0, 1'b0, 1'b0, 4'h0));
        reset = 1'b0;
        step;
        step;
        chk("idle_no_start", 0, pk(4'h0, 1'b0, 1'b0, 4'h0));

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) rom[i] = 4'(i);
            rom[0] = vecs[v].r0;
            rom[1] = vecs[v].r1;
            rom[2] = vecs[v].r2;
            round  = vecs[v].rnd;
            speed  = vecs[v].spd;
            start  = 1'b1;
            per    = 2 + vecs[v].show_c + vecs[v].gap_c;
            total  = 1 + (int'(vecs[v].rnd) + 1) * per;
            for (int c = 1; c <= total; c++) begin
                step;
                if (c == total) begin
                    chk("play_done", c, pk(4'h0, 1'b0, 1'b1, vecs[v].rnd));
                end else begin
                    k = (c - 1) / per;
                    o = (c - 1) % per;
                    chk("play", c, pk((o >= 2 && o < 2 + vecs[v].show_c) ? rom[k] : 4'h0,
                                      1'b1, 1'b0, 4'(k)));
                end
                if (c == 4) begin
                    round = ~vecs[v].rnd;
                    speed = ~vecs[v].spd;
                end
            end
            step;
            chk("done_hold", total + 1, pk(4'h0, 1'b0, 1'b1, vecs[v].rnd));
            start = 1'b0;
            step;
            chk("done_to_idle", total + 2, pk(4'h0, 1'b0, 1'b0, vecs[v].rnd));
        end

        // Abort during the second SHOW of round 3, then restart from idx 0.
        for (int i = 0; i < 16; i++) rom[i] = 4'(i + 1);
        round = 4'd3;
        speed = 2'b11;
        start = 1'b1;
        for (int c = 1; c <= 18; c++) step;
        chk("abort_pre_show2", 18, pk(4'h2, 1'b1, 1'b0, 4'h1));
        start = 1'b0;
        step;
        chk("abort_idle", 19, pk(4'h0, 1'b0, 1'b0, 4'h1));
        step;
        step;
        step;
        chk("abort_no_end", 22, pk(4'h0, 1'b0, 1'b0, 4'h1));
        start = 1'b1;
        step;
        chk("restart_fetch", 1, pk(4'h0, 1'b1, 1'b0, 4'h0));
        step;
        step;
        chk("restart_show0", 3, pk(4'h1, 1'b1, 1'b0, 4'h0));

        // Reset pulse during the first GAP with start held high.
        start = 1'b0;
        step;
        round = 4'd2;
        speed = 2'b11;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) step;
        chk("gap_before_reset", 12, pk(4'h0, 1'b1, 1'b0, 4'h0));
        reset = 1'b1;
        step;
        chk("reset_in_gap", 13, pk(4'h0, 1'b0, 1'b0, 4'h0));
        reset = 1'b0;
        step;
        chk("post_reset_fetch", 1, pk(4'h0, 1'b1, 1'b0, 4'h0));
        step;
        step;
        chk("post_reset_show0", 3, pk(4'h1, 1'b1, 1'b0, 4'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clock_50 cycles per display tick (0.1 s at 50 MHz); 4 in simulation.
REQ-002 Parameter SEQ_W, default 4, width of one sequence element and of the LED bus.
REQ-003 clock_50  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  level enable from the game controller (e3); high for the whole FPGA-play phase.
REQ-006 round  input  4  current round 0..15; round+1 elements are played.
REQ-007 speed  input  2  difficulty: 00 slow … 11 fast.
REQ-008 rom_addr  output  4  address into the synchronous pattern ROM.
REQ-009 rom_data  input  SEQ_W  ROM output, valid one cycle after rom_addr.
REQ-010 led_out  output  SEQ_W  element currently displayed; all-zero when not showing.
REQ-011 busy  output  1  high in any state other than IDLE and DONE.
REQ-012 end_fpga  output  1  sequence complete; status to the game controller.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, LATCH, SHOW, GAP and DONE.
REQ-014 In IDLE, when start=1, the block SHALL latch round and speed, clear idx to 0 and go to FETCH.
REQ-015 FETCH SHALL drive rom_addr=idx for one cycle, then go to LATCH.
REQ-016 LATCH SHALL wait one cycle and, on leaving, capture rom_data into the led register and go to SHOW.
REQ-017 show_ticks SHALL be 8, 6, 4 or 2 for latched speed 00, 01, 10 or 11; gap_ticks SHALL be show_ticks/2.
REQ-018 On entry to SHOW or GAP the prescaler SHALL clear, so SHOW lasts exactly show_ticks*TICK_DIV cycles and GAP exactly gap_ticks*TICK_DIV cycles.
REQ-019 The tick pulse SHALL fire when the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
REQ-020 led_out SHALL equal the captured element during SHOW and 0 in every other state.
REQ-021 Leaving GAP, the block SHALL go to DONE if idx equals the latched round, otherwise increment idx and go to FETCH.
REQ-022 A GAP is played after the last element too, so every element's period is uniform.
REQ-023 In DONE, end_fpga SHALL be 1; when start=0, the block SHALL return to IDLE and drop end_fpga.
REQ-024 Round=15 SHALL play 16 elements at idx 0..15; idx SHALL never wrap.
REQ-025 If start falls in FETCH, LATCH, SHOW or GAP, the block SHALL abort to IDLE on the next edge, with led_out=0 and no end_fpga pulse.
REQ-026 Changes to round or speed while busy SHALL have no effect until the next start.
REQ-027 If start is still high one cycle after returning to IDLE, a new sequence SHALL begin (no edge detection).

Reset
REQ-028 While reset=1 the block SHALL load: state IDLE, idx 0, prescaler 0, tick counter 0, led register 0, rom_addr 0, busy 0, end_fpga 0.
REQ-029 Reset SHALL take priority over start and every other input, including mid-sequence.
REQ-030 The first action after reset is released SHALL require start=1 sampled in IDLE.

Structure
REQ-031 The state encodings and the speed-to-show_ticks table SHALL live in the shared package seq_pkg, for reuse by the game controller and benches.
REQ-032 The prescaler SHALL be a sub-module tick_gen (inputs clock_50, reset, clear; output tick), parameterised by TICK_DIV.
REQ-033 The FSM, idx counter and tick counter SHALL be in seq_player; the ROM is external.

Verification (TICK_DIV=4)
REQ-034 round=0, speed=11, ROM[0]=4'hA, start held high from edge 0:
  - led_out=4'hA for cycles 3..10;
  - led_out=0 for cycles 11..14;
  - end_fpga=1 from cycle 15.
REQ-035 round=2, speed=00, ROM=1,2,4:
  - led_out shows 1, 2, 4, each for 32 cycles, separated by 16-cycle gaps;
  - rom_addr steps 0, 1, 2;
  - end_fpga rises after the third gap.
REQ-036 round=15, speed=11, ROM[i]=i:
  - 16 elements, 0..15, are shown;
  - rom_addr never exceeds 15;
  - end_fpga rises exactly once.
REQ-037 start dropped during the second SHOW of round=3:
  - IDLE and led_out=0 on the next edge;
  - end_fpga stays 0;
  - a restart replays from idx 0.
REQ-038 reset pulsed for 1 cycle during GAP:
  - all outputs at reset values on the next edge;
  - with start still high, the sequence restarts from idx 0 one cycle after reset drops.
REQ-039 speed changed from 11 to 00 mid-sequence: durations stay 8/4 cycles until DONE.
